lfsr_keystream_sched: RTL and testbench

Shared keystream scheduler for the 8-bit LFSR stream cipher. Two byte requesters each have a valid/ready channel; a round-robin arbiter grants one byte per cycle. The granted byte is XORed with the current LFSR state, and the LFSR advances exactly one step per consumed byte. The block also sequences seed loading and an optional warm-up run. It sits between the host-side byte sources and the cipher output port.

---
 rtl/lfsr_cipher_pkg.sv | 16 +
 rtl/lfsr_keystream_sched_arb.sv | 30 +++
 rtl/lfsr_keystream_sched.sv | 107 ++++++++++
 tb/tb_lfsr_keystream_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_cipher_pkg.sv
// Shared types and LFSR helper for the 8-bit LFSR stream cipher blocks.
package lfsr_cipher_pkg;
  localparam int LFSR_W = 8;
  // Feedback taps at bits 7, 6, 5 and 0
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hE1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WARMUP = 2'd2
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/lfsr_keystream_sched_arb.sv
// Two-way round-robin arbiter: one-hot grant; the pointer moves away from each winner.
module lfsr_rr_arb2
  import lfsr_cipher_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_en,
  output logic [1:0] o_grant
);
  logic r_rr;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      unique case (i_valid)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_rr ? 2'b10 : 2'b01;
        default: o_grant = 2'b00;
      endcase
    end
  end

  // o_grant[1] is the granted index; point at the other channel next time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_rr <= 1'b0;
    else if (|o_grant) r_rr <= ~o_grant[1];
  end
endmodule

// File: rtl/lfsr_keystream_sched.sv
// Keystream scheduler: two requesters share one LFSR, with seed load and warm-up sequencing.
module lfsr_keystream_sched
  import lfsr_cipher_pkg::*;
#(
  parameter int unsigned        WARMUP_STEPS = 8,
  parameter logic [LFSR_W-1:0]  RESET_SEED   = 8'h41
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed_data,
  output logic              seed_ready,
  input  logic              req0_valid,
  input  logic [LFSR_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [LFSR_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [LFSR_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic              busy
);
  localparam logic [7:0] WU_INIT = 8'((WARMUP_STEPS == 0) ? 0 : WARMUP_STEPS - 1);

  state_e            r_state;
  logic [LFSR_W-1:0] r_lfsr, r_seed, r_out_data;
  logic [7:0]        r_cnt;
  logic              r_out_valid, r_out_src, r_live;
  logic              w_slot_free, w_seed_acc, w_arb_en, w_fire, w_gidx;
  logic [1:0]        w_grant;
  logic [LFSR_W-1:0] w_gdata;

  // r_live keeps every ready low until the first edge after reset
  assign w_slot_free = !r_out_valid || out_ready;
  assign seed_ready  = r_live && (r_state == ST_RUN) && !r_out_valid;
  assign w_seed_acc  = seed_valid && seed_ready;
  assign w_arb_en    = r_live && (r_state == ST_RUN) && w_slot_free && !w_seed_acc;

  lfsr_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid ({req1_valid, req0_valid}),
    .i_en    (w_arb_en),
    .o_grant (w_grant)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign w_fire     = |w_grant;
  assign w_gidx     = w_grant[1];
  assign w_gdata    = w_gidx ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_lfsr  <= RESET_SEED;
      r_seed  <= '0;
      r_cnt   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      unique case (r_state)
        ST_RUN: begin
          if (w_seed_acc) begin
            r_seed  <= seed_data;
            r_state <= ST_LOAD;
          end else if (w_fire) begin
            r_lfsr <= lfsr_next(r_lfsr);
          end
        end
        ST_LOAD: begin
          r_lfsr  <= (r_seed == '0) ? RESET_SEED : r_seed;
          r_cnt   <= WU_INIT;
          r_state <= (WARMUP_STEPS > 0) ? ST_WARMUP : ST_RUN;
        end
        ST_WARMUP: begin
          // Counter reads 0 on the last stepping cycle
          r_lfsr <= lfsr_next(r_lfsr);
          if (r_cnt == 8'd0) r_state <= ST_RUN;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
    end else if (w_slot_free) begin
      r_out_valid <= w_fire;
      if (w_fire) begin
        r_out_data <= w_gdata ^ r_lfsr;
        r_out_src  <= w_gidx;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign busy      = (r_state != ST_RUN);
endmodule

// File: tb/tb_lfsr_keystream_sched.sv
// Bench for lfsr_keystream_sched: vector table, seed/warm-up sequences, randomized model check.
module tb_lfsr_keystream_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sv, sr, v0, r0, v1, r1, ov, os, ordy, busy;
  logic [7:0] sd, d0, d1, od;
  logic       sv_b, sr_b, v0_b, r0_b, v1_b, r1_b, ov_b, os_b, ordy_b, busy_b;
  logic [7:0] sd_b, d0_b, d1_b, od_b;

  lfsr_keystream_sched #(.WARMUP_STEPS(2), .RESET_SEED(8'h41)) dut (
    .clk(clk), .rst_n(rst_n),
    .seed_valid(sv), .seed_data(sd), .seed_ready(sr),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .out_valid(ov), .out_data(od), .out_src(os), .out_ready(ordy), .busy(busy)
  );

  lfsr_keystream_sched #(.WARMUP_STEPS(0), .RESET_SEED(8'h41)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .seed_valid(sv_b), .seed_data(sd_b), .seed_ready(sr_b),
    .req0_valid(v0_b), .req0_data(d0_b), .req0_ready(r0_b),
    .req1_valid(v1_b), .req1_data(d1_b), .req1_ready(r1_b),
    .out_valid(ov_b), .out_data(od_b), .out_src(os_b), .out_ready(ordy_b), .busy(busy_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h want %02h", name, act, exp);
  endtask

  // Spec LFSR step: shift left, feed back the parity of bits 7,6,5,0
  function automatic logic [7:0] ref_step(input logic [7:0] q);
    logic fb;
    fb = ($countones(q & 8'hE1) % 2) == 1;
    return {q[6:0], fb};
  endfunction

  function automatic logic [7:0] ref_warm(input logic [7:0] s, input int n);
    logic [7:0] q;
    q = (s == 8'h00) ? 8'h41 : s;
    for (int k = 0; k < n; k++) q = ref_step(q);
    return q;
  endfunction

  task automatic idle_b();
    sv_b = 0; sd_b = 0; v0_b = 0; d0_b = 0; v1_b = 0; d1_b = 0; ordy_b = 1;
  endtask

  task automatic do_reset();
    rst_n = 0; sv = 1; sd = 0; v0 = 1; v1 = 1; d0 = 0; d1 = 0; ordy = 1;
    idle_b();
    #3;
    chk1("rst.seed_ready", sr, 1'b0);
    chk1("rst.req0_ready", r0, 1'b0);
    chk1("rst.req1_ready", r1, 1'b0);
    chk1("rst.out_valid", ov, 1'b0);
    chk8("rst.out_data", od, 8'h00);
    chk1("rst.out_src", os, 1'b0);
    chk1("rst.busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk1("rel.req0_ready", r0, 1'b0);
    chk1("rel.seed_ready", sr, 1'b0);
    sv = 0; v0 = 0; v1 = 0;
    @(negedge clk);
  endtask

  typedef struct {
    logic       rst;
    logic       v0; logic [7:0] d0;
    logic       v1; logic [7:0] d1;
    logic       ordy;
    logic       e_r0, e_r1, e_ov;
    logic [7:0] e_od;
    logic       e_os;
  } vec_t;

  vec_t tbl[$];

  logic [7:0] m_lfsr, m_od;
  logic       m_rr, m_ov, m_os, sfree, acc, e_sr;
  int         m_busy, g;

  initial begin
    // rst, v0,d0, v1,d1, ordy | rdy0,rdy1, ov,od,os
    tbl.push_back('{1, 1,8'h00, 0,8'h00, 1,  1,0, 0,8'h00,0});
    tbl.push_back('{0, 1,8'h00, 0,8'h00, 1,  1,0, 1,8'h41,0});
    tbl.push_back('{0, 1,8'h00, 0,8'h00, 1,  1,0, 1,8'h82,0});
    tbl.push_back('{0, 0,8'h00, 0,8'h00, 1,  0,0, 1,8'h05,0});
    tbl.push_back('{0, 0,8'h00, 0,8'h00, 1,  0,0, 0,8'h00,0});
    tbl.push_back('{1, 1,8'h00, 1,8'h00, 1,  1,0, 0,8'h00,0});
    tbl.push_back('{0, 1,8'h00, 1,8'h00, 1,  0,1, 1,8'h41,0});
    tbl.push_back('{0, 1,8'h00, 1,8'h00, 1,  1,0, 1,8'h82,1});
    tbl.push_back('{0, 1,8'h00, 1,8'h00, 1,  0,1, 1,8'h05,0});
    tbl.push_back('{0, 0,8'h00, 0,8'h00, 1,  0,0, 1,8'h0B,1});
    tbl.push_back('{1, 0,8'h00, 1,8'hFF, 0,  0,1, 0,8'h00,0});
    tbl.push_back('{0, 0,8'h00, 1,8'hFF, 0,  0,0, 1,8'hBE,1});
    tbl.push_back('{0, 0,8'h00, 1,8'hFF, 0,  0,0, 1,8'hBE,1});
    tbl.push_back('{0, 0,8'h00, 1,8'hFF, 0,  0,0, 1,8'hBE,1});
    tbl.push_back('{0, 0,8'h00, 1,8'hFF, 1,  0,1, 1,8'hBE,1});
    tbl.push_back('{0, 0,8'h00, 0,8'h00, 1,  0,0, 1,8'h7D,1});
    tbl.push_back('{0, 0,8'h00, 0,8'h00, 1,  0,0, 0,8'h00,0});

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      v0 = tbl[i].v0; d0 = tbl[i].d0; v1 = tbl[i].v1; d1 = tbl[i].d1; ordy = tbl[i].ordy;
      #1;
      chk1($sformatf("t%0d.req0_ready", i), r0, tbl[i].e_r0);
      chk1($sformatf("t%0d.req1_ready", i), r1, tbl[i].e_r1);
      chk1($sformatf("t%0d.out_valid", i), ov, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        chk8($sformatf("t%0d.out_data", i), od, tbl[i].e_od);
        chk1($sformatf("t%0d.out_src", i), os, tbl[i].e_os);
      end
      @(negedge clk);
    end

    // Seed beats a same-cycle request; LOAD + 2 warm-up cycles are busy
    do_reset();
    sv = 1; sd = 8'h41; v0 = 1; d0 = 8'h00;
    #1;
    chk1("wu.seed_ready", sr, 1'b1);
    chk1("wu.req0_blocked", r0, 1'b0);
    @(negedge clk);
    sv = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1($sformatf("wu.busy%0d", k), busy, 1'b1);
      chk1($sformatf("wu.req0_ready%0d", k), r0, 1'b0);
      chk1($sformatf("wu.seed_ready%0d", k), sr, 1'b0);
      @(negedge clk);
    end
    #1;
    chk1("wu.busy_done", busy, 1'b0);
    chk1("wu.req0_ready", r0, 1'b1);
    @(negedge clk);
    v0 = 0;
    #1;
    chk1("wu.out_valid", ov, 1'b1);
    chk8("wu.out_data", od, 8'h05);
    chk1("wu.out_src", os, 1'b0);
    @(negedge clk);

    // Reset during WARMUP abandons it and restores RESET_SEED
    sv = 1; sd = 8'h5A;
    #1;
    chk1("rwu.seed_ready", sr, 1'b1);
    @(negedge clk);
    sv = 0;
    @(negedge clk);
    #1;
    chk1("rwu.busy_in_warmup", busy, 1'b1);
    rst_n = 0;
    #1;
    chk1("rwu.busy_rst", busy, 1'b0);
    chk1("rwu.out_valid_rst", ov, 1'b0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk1("rwu.busy_rel", busy, 1'b0);
    @(negedge clk);
    v0 = 1; d0 = 8'h00;
    #1;
    chk1("rwu.req0_ready", r0, 1'b1);
    @(negedge clk);
    v0 = 0;
    #1;
    chk1("rwu.out_valid", ov, 1'b1);
    chk8("rwu.out_data", od, 8'h41);

    // No warm-up instance: explicit seed, then zero-seed substitution
    do_reset();
    sv_b = 1; sd_b = 8'h82;
    #1;
    chk1("nw.seed_ready", sr_b, 1'b1);
    @(negedge clk);
    sv_b = 0;
    #1;
    chk1("nw.busy_load", busy_b, 1'b1);
    @(negedge clk);
    v0_b = 1; d0_b = 8'h00;
    #1;
    chk1("nw.busy_run", busy_b, 1'b0);
    chk1("nw.req0_ready", r0_b, 1'b1);
    @(negedge clk);
    v0_b = 0;
    #1;
    chk8("nw.out_data", od_b, 8'h82);
    @(negedge clk);
    sv_b = 1; sd_b = 8'h00;
    #1;
    chk1("nw.seed0_ready", sr_b, 1'b1);
    @(negedge clk);
    sv_b = 0;
    @(negedge clk);
    v0_b = 1;
    #1;
    chk1("nw.req0_ready2", r0_b, 1'b1);
    @(negedge clk);
    v0_b = 0;
    #1;
    chk1("nw.out_valid2", ov_b, 1'b1);
    chk8("nw.out_data2", od_b, 8'h41);

    // Randomized traffic against the reference model (warm-up of 2)
    do_reset();
    m_lfsr = 8'h41; m_rr = 0; m_ov = 0; m_od = 0; m_os = 0; m_busy = 0;
    for (int c = 0; c < 600; c++) begin
      v0 = 1'($urandom_range(0, 1)); d0 = 8'($urandom);
      v1 = 1'($urandom_range(0, 1)); d1 = 8'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      sv = ($urandom_range(0, 11) == 0);
      sd = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      #1;
      e_sr  = (m_busy == 0) && !m_ov;
      sfree = !m_ov || ordy;
      acc   = sv && e_sr;
      g = -1;
      if (m_busy == 0 && sfree && !acc) begin
        if (v0 && v1) g = m_rr ? 1 : 0;
        else if (v0)  g = 0;
        else if (v1)  g = 1;
      end
      chk1($sformatf("rnd%0d.seed_ready", c), sr, e_sr);
      chk1($sformatf("rnd%0d.req0_ready", c), r0, g == 0);
      chk1($sformatf("rnd%0d.req1_ready", c), r1, g == 1);
      chk1($sformatf("rnd%0d.busy", c), busy, m_busy != 0);
      chk1($sformatf("rnd%0d.out_valid", c), ov, m_ov);
      if (m_ov) begin
        chk8($sformatf("rnd%0d.out_data", c), od, m_od);
        chk1($sformatf("rnd%0d.out_src", c), os, m_os);
      end
      if (sfree) begin
        m_ov = (g >= 0);
        if (g >= 0) begin
          m_od   = ((g == 1) ? d1 : d0) ^ m_lfsr;
          m_os   = (g == 1);
          m_lfsr = ref_step(m_lfsr);
          m_rr   = (g == 0);
        end
      end
      if (acc) begin
        m_lfsr = ref_warm(sd, 2);
        m_busy = 3;
      end else if (m_busy > 0) begin
        m_busy--;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
